// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, accumulator source selects,
// sequencer states and the instruction-length helper.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_IN   = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_ALU  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_JP   = 4'h8;
  localparam logic [3:0] OP_OUT  = 4'h9;
  localparam logic [3:0] OP_OFF  = 4'hA;
  localparam logic [3:0] OP_JMPR = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] MUX_ALU  = 2'd0;
  localparam logic [1:0] MUX_RF   = 2'd1;
  localparam logic [1:0] MUX_IMM  = 2'd2;
  localparam logic [1:0] MUX_USER = 2'd3;

  typedef enum logic [2:0] {
    StFetch,
    StOperand,
    StExecute,
    StWaitIn,
    StWaitRelease,
    StHalt
  } state_e;

  function automatic logic two_byte(input logic [3:0] opcode);
    logic res;
    case (opcode)
      OP_LDI, OP_ALU, OP_JMP, OP_JZ, OP_JP, OP_JMPR: res = 1'b1;
      default:                                      res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Combinational decode of sequencer state and instruction into datapath strobes,
// accumulator source select, jump decision and instruction length.
module instruction_decoder
  import cpu_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] ir_op_i,
  input  logic [7:0] operand_i,
  input  logic [3:0] fetch_op_i,
  input  logic       user_enter_i,
  input  logic       z_i,
  input  logic       p_i,
  input  logic [7:0] branch_address_i,
  output logic       acc_enable_o,
  output logic       rf_write_o,
  output logic [1:0] mux_select_o,
  output logic       jump_o,
  output logic [7:0] jump_target_o,
  output logic       two_byte_o,
  output logic       out_set_o,
  output logic       out_clr_o
);

  always_comb begin
    acc_enable_o  = 1'b0;
    rf_write_o    = 1'b0;
    mux_select_o  = MUX_ALU;
    jump_o        = 1'b0;
    jump_target_o = operand_i;
    out_set_o     = 1'b0;
    out_clr_o     = 1'b0;
    two_byte_o    = two_byte(fetch_op_i);

    if (state_i == StWaitIn) begin
      mux_select_o = MUX_USER;
      acc_enable_o = user_enter_i;
    end else if (state_i == StExecute) begin
      case (ir_op_i)
        OP_LDA: begin
          acc_enable_o = 1'b1;
          mux_select_o = MUX_RF;
        end
        OP_STA: rf_write_o = 1'b1;
        OP_LDI: begin
          acc_enable_o = 1'b1;
          mux_select_o = MUX_IMM;
        end
        OP_ALU:  acc_enable_o = 1'b1;
        OP_JMP:  jump_o = 1'b1;
        OP_JZ:   jump_o = z_i;
        OP_JP:   jump_o = p_i;
        OP_JMPR: begin
          jump_o        = 1'b1;
          jump_target_o = branch_address_i;
        end
        OP_OUT:  out_set_o = 1'b1;
        OP_OFF:  out_clr_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer for the 8-bit accumulator CPU: fetch/operand/execute FSM,
// program counter, flag latches, user-input handshake and halt.
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       user_enter,
  input  logic       zero_flag_in,
  input  logic       positive_flag_in,
  input  logic [7:0] branch_address_in,
  output logic [1:0] mux_select,
  output logic [7:0] imm_data,
  output logic       acc_enable,
  output logic       rf_write,
  output logic [2:0] rf_address,
  output logic [3:0] alu_select,
  output logic [1:0] alu_rotate,
  output logic       output_enable,
  output logic       waiting_input,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [3:0] op_q, op_d;
  logic [2:0] reg_q, reg_d;
  logic [7:0] operand_q, operand_d;
  logic       z_q, z_d;
  logic       p_q, p_d;
  logic       oe_q, oe_d;

  logic       jump;
  logic [7:0] jump_target;
  logic       is_two_byte;
  logic       out_set;
  logic       out_clr;

  instruction_decoder u_decoder (
    .state_i          (state_q),
    .ir_op_i          (op_q),
    .operand_i        (operand_q),
    .fetch_op_i       (prog_data[7:4]),
    .user_enter_i     (user_enter),
    .z_i              (z_q),
    .p_i              (p_q),
    .branch_address_i (branch_address_in),
    .acc_enable_o     (acc_enable),
    .rf_write_o       (rf_write),
    .mux_select_o     (mux_select),
    .jump_o           (jump),
    .jump_target_o    (jump_target),
    .two_byte_o       (is_two_byte),
    .out_set_o        (out_set),
    .out_clr_o        (out_clr)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    reg_d     = reg_q;
    operand_d = operand_q;
    z_d       = z_q;
    p_d       = p_q;
    oe_d      = oe_q;

    unique case (state_q)
      StFetch: begin
        op_d    = prog_data[7:4];
        reg_d   = prog_data[2:0];
        pc_d    = pc_q + 8'd1;
        state_d = is_two_byte ? StOperand : StExecute;
      end
      StOperand: begin
        operand_d = prog_data;
        pc_d      = pc_q + 8'd1;
        state_d   = StExecute;
      end
      StExecute: begin
        if (jump) pc_d = jump_target;
        if (out_set) oe_d = 1'b1;
        if (out_clr) oe_d = 1'b0;
        case (op_q)
          OP_IN:   state_d = StWaitIn;
          OP_HALT: state_d = StHalt;
          default: state_d = StFetch;
        endcase
      end
      StWaitIn:      if (user_enter) state_d = StWaitRelease;
      StWaitRelease: if (!user_enter) state_d = StFetch;
      StHalt:        state_d = StHalt;
      default:       state_d = StFetch;
    endcase

    // Flags track whatever the accumulator is loaded with, on the same edge.
    if (acc_enable) begin
      z_d = zero_flag_in;
      p_d = positive_flag_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      op_q      <= 4'h0;
      reg_q     <= 3'h0;
      operand_q <= 8'h00;
      z_q       <= 1'b1;
      p_q       <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      reg_q     <= reg_d;
      operand_q <= operand_d;
      z_q       <= z_d;
      p_q       <= p_d;
      oe_q      <= oe_d;
    end
  end

  assign prog_addr     = pc_q;
  assign imm_data      = operand_q;
  assign rf_address    = reg_q;
  assign alu_select    = operand_q[7:4];
  assign alu_rotate    = operand_q[1:0];
  assign output_enable = oe_q;
  assign waiting_input = (state_q == StWaitIn) || (state_q == StWaitRelease);
  assign halted        = (state_q == StHalt);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed ROM programs, expected datapath strobes queued by the
// stimulus and checked by an independent monitor, plus timed PC/status checks.
module tb_control_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;
  logic       user_enter = 1'b0;
  logic       zero_flag_in = 1'b0;
  logic       positive_flag_in = 1'b0;
  logic [7:0] branch_address_in = 8'h00;
  logic [1:0] mux_select;
  logic [7:0] imm_data;
  logic       acc_enable;
  logic       rf_write;
  logic [2:0] rf_address;
  logic [3:0] alu_select;
  logic [1:0] alu_rotate;
  logic       output_enable;
  logic       waiting_input;
  logic       halted;

  logic [7:0] rom [256];
  assign prog_data = rom[prog_addr];

  control_unit dut (
    .clock             (clock),
    .reset             (reset),
    .prog_addr         (prog_addr),
    .prog_data         (prog_data),
    .user_enter        (user_enter),
    .zero_flag_in      (zero_flag_in),
    .positive_flag_in  (positive_flag_in),
    .branch_address_in (branch_address_in),
    .mux_select        (mux_select),
    .imm_data          (imm_data),
    .acc_enable        (acc_enable),
    .rf_write          (rf_write),
    .rf_address        (rf_address),
    .alu_select        (alu_select),
    .alu_rotate        (alu_rotate),
    .output_enable     (output_enable),
    .waiting_input     (waiting_input),
    .halted            (halted)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       acc;
    logic       rf;
    logic       mux_chk;
    logic [1:0] mux;
    logic [7:0] imm;
    logic [2:0] rfa;
    logic [3:0] alu;
    logic [1:0] rot;
  } strobe_t;

  strobe_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected strobe cycle; alu/rotate fields follow from the operand register value.
  task automatic push(input logic acc, input logic rf, input logic mchk, input logic [1:0] mux,
                      input logic [7:0] imm, input logic [2:0] rfa);
    strobe_t s;
    s.acc = acc; s.rf = rf; s.mux_chk = mchk; s.mux = mux;
    s.imm = imm; s.rfa = rfa; s.alu = imm[7:4]; s.rot = imm[1:0];
    exp_q.push_back(s);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start_prog();
    reset = 1'b0;
    user_enter = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: every strobe cycle must match the next queued expectation.
  initial begin
    strobe_t act, exp;
    forever begin
      @(negedge clock);
      if (reset && (acc_enable || rf_write)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got acc=%0b rf=%0b mux=%0d, expected none (t=%0t)",
                   acc_enable, rf_write, mux_select, $time);
        end else begin
          exp = exp_q.pop_front();
          act.acc = acc_enable; act.rf = rf_write; act.mux_chk = exp.mux_chk;
          act.mux = exp.mux_chk ? mux_select : exp.mux;
          act.imm = imm_data; act.rfa = rf_address; act.alu = alu_select; act.rot = alu_rotate;
          if (act !== exp) begin
            errors++;
            $display("FAIL strobe: got acc=%0b rf=%0b mux=%0d imm=%02h rfa=%0d alu=%h rot=%0d, expected acc=%0b rf=%0b mux=%0d imm=%02h rfa=%0d alu=%h rot=%0d (t=%0t)",
                     act.acc, act.rf, act.mux, act.imm, act.rfa, act.alu, act.rot,
                     exp.acc, exp.rf, exp.mux, exp.imm, exp.rfa, exp.alu, exp.rot, $time);
          end
        end
      end
    end
  end

  initial begin
    start_prog();
    #1;
    chk("rst_prog_addr", prog_addr, 8'h00);
    chk("rst_strobes", 8'({acc_enable, rf_write}), 8'h00);
    chk("rst_status", 8'({output_enable, waiting_input, halted}), 8'h00);
    chk("rst_imm", imm_data, 8'h00);
    chk("rst_rf_address", 8'(rf_address), 8'h00);

    // Reset mid-ALU after OUT, then JP/JZ prove Z=P=1 with live flags low.
    rom[8'h00] = 8'h90; rom[8'h01] = 8'h50; rom[8'h02] = 8'h3C;
    zero_flag_in = 1'b0; positive_flag_in = 1'b0;
    release_reset();
    tick(2);
    chk("out_raises_oe", 8'(output_enable), 8'h01);
    tick(1);
    chk("pc_in_operand", prog_addr, 8'h02);
    reset = 1'b0;
    #1;
    chk("midrst_pc", prog_addr, 8'h00);
    chk("midrst_acc", 8'(acc_enable), 8'h00);
    chk("midrst_oe", 8'(output_enable), 8'h00);
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h80; rom[8'h01] = 8'h30;
    rom[8'h30] = 8'h70; rom[8'h31] = 8'h40;
    rom[8'h40] = 8'hF0;
    tick(2);
    chk("held_rst_pc", prog_addr, 8'h00);
    release_reset();
    tick(3);
    chk("jp_reset_p", prog_addr, 8'h30);
    tick(3);
    chk("jz_reset_z", prog_addr, 8'h40);
    tick(2);
    chk("halt1", 8'(halted), 8'h01);

    // LDI 05 / STA R3 / ALU A6
    start_prog();
    rom[8'h00] = 8'h40; rom[8'h01] = 8'h05; rom[8'h02] = 8'h33;
    rom[8'h03] = 8'h50; rom[8'h04] = 8'hA6; rom[8'h05] = 8'hF0;
    zero_flag_in = 1'b0; positive_flag_in = 1'b1;
    push(1'b1, 1'b0, 1'b1, 2'd2, 8'h05, 3'd0);
    push(1'b0, 1'b1, 1'b0, 2'd0, 8'h05, 3'd3);
    push(1'b1, 1'b0, 1'b1, 2'd0, 8'hA6, 3'd0);
    release_reset();
    tick(2);
    chk("ldi_acc_cycle3", 8'(acc_enable), 8'h01);
    chk("ldi_mux", 8'(mux_select), 8'h02);
    chk("ldi_imm", imm_data, 8'h05);
    tick(2);
    chk("sta_rf_write_cycle5", 8'(rf_write), 8'h01);
    chk("sta_rf_address", 8'(rf_address), 8'h03);
    tick(3);
    chk("alu_acc", 8'(acc_enable), 8'h01);
    chk("alu_select", 8'(alu_select), 8'h0A);
    chk("alu_rotate", 8'(alu_rotate), 8'h02);
    tick(3);
    chk("halt2", 8'(halted), 8'h01);
    chk("halt2_pc", prog_addr, 8'h06);

    // JZ taken on latched Z, then untaken JZ/JP after loading 80
    start_prog();
    rom[8'h00] = 8'h40; rom[8'h01] = 8'h00; rom[8'h02] = 8'h70; rom[8'h03] = 8'h20;
    rom[8'h20] = 8'h40; rom[8'h21] = 8'h80; rom[8'h22] = 8'h70; rom[8'h23] = 8'h30;
    rom[8'h24] = 8'h80; rom[8'h25] = 8'h40; rom[8'h26] = 8'hF0;
    zero_flag_in = 1'b1; positive_flag_in = 1'b0;
    push(1'b1, 1'b0, 1'b1, 2'd2, 8'h00, 3'd0);
    push(1'b1, 1'b0, 1'b1, 2'd2, 8'h80, 3'd0);
    release_reset();
    tick(3);
    zero_flag_in = 1'b0;
    tick(3);
    chk("jz_taken", prog_addr, 8'h20);
    tick(3);
    zero_flag_in = 1'b1; positive_flag_in = 1'b1;
    tick(3);
    chk("jz_untaken", prog_addr, 8'h24);
    tick(3);
    chk("jp_untaken", prog_addr, 8'h26);
    tick(2);
    chk("halt3", 8'(halted), 8'h01);

    // IN with key pressed late and held, then IN with key already down
    start_prog();
    rom[8'h00] = 8'h10; rom[8'h01] = 8'h11; rom[8'h02] = 8'hF0;
    push(1'b1, 1'b0, 1'b1, 2'd3, 8'h00, 3'd0);
    push(1'b1, 1'b0, 1'b1, 2'd3, 8'h00, 3'd1);
    release_reset();
    tick(1);
    chk("in_exec_not_waiting", 8'(waiting_input), 8'h00);
    tick(1);
    chk("wait_in_flag", 8'(waiting_input), 8'h01);
    chk("wait_in_mux", 8'(mux_select), 8'h03);
    chk("wait_in_no_acc", 8'(acc_enable), 8'h00);
    tick(2);
    chk("wait_in_still", 8'(waiting_input), 8'h01);
    user_enter = 1'b1;
    #1;
    chk("capture_acc", 8'(acc_enable), 8'h01);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("held_waiting", 8'({waiting_input, acc_enable}), 8'h02);
    end
    user_enter = 1'b0;
    tick(1);
    chk("released_waiting", 8'(waiting_input), 8'h00);
    chk("released_pc", prog_addr, 8'h01);
    user_enter = 1'b1;
    tick(2);
    chk("early_key_acc", 8'(acc_enable), 8'h01);
    chk("early_key_rfa", 8'(rf_address), 8'h01);
    tick(1);
    chk("early_key_release_wait", 8'({waiting_input, acc_enable}), 8'h02);
    user_enter = 1'b0;
    tick(3);
    chk("halt4", 8'(halted), 8'h01);

    // PC wrap between opcode and operand
    start_prog();
    rom[8'h00] = 8'h60; rom[8'h01] = 8'hFF; rom[8'hFF] = 8'h40;
    push(1'b1, 1'b0, 1'b1, 2'd2, 8'h07, 3'd0);
    release_reset();
    tick(3);
    chk("jmp_ff", prog_addr, 8'hFF);
    rom[8'h00] = 8'h07; rom[8'h01] = 8'hF0;
    tick(1);
    chk("wrap_pc", prog_addr, 8'h00);
    tick(1);
    chk("wrap_operand", imm_data, 8'h07);
    tick(1);
    chk("wrap_next_fetch", prog_addr, 8'h01);
    tick(2);
    chk("halt5_pc", prog_addr, 8'h02);

    // JMPR, OUT/OFF and HALT freeze
    start_prog();
    rom[8'h00] = 8'hB2; rom[8'h01] = 8'h5D;
    rom[8'h47] = 8'h90; rom[8'h48] = 8'hA0; rom[8'h49] = 8'h90; rom[8'h4A] = 8'hF0;
    branch_address_in = 8'h47;
    release_reset();
    tick(2);
    chk("jmpr_alu_select", 8'(alu_select), 8'h05);
    chk("jmpr_alu_rotate", 8'(alu_rotate), 8'h01);
    chk("jmpr_rf_address", 8'(rf_address), 8'h02);
    tick(1);
    chk("jmpr_target", prog_addr, 8'h47);
    tick(2);
    chk("out_on", 8'(output_enable), 8'h01);
    tick(2);
    chk("off", 8'(output_enable), 8'h00);
    tick(2);
    chk("out_on_again", 8'(output_enable), 8'h01);
    tick(2);
    chk("halted", 8'(halted), 8'h01);
    chk("halt_pc", prog_addr, 8'h4B);
    branch_address_in = 8'h00;
    for (int i = 0; i < 20; i++) begin
      user_enter = i[0];
      tick(1);
      chk("halt_frozen_pc", prog_addr, 8'h4B);
      chk("halt_state", 8'({halted, output_enable, acc_enable, rf_write}), 8'h0C);
    end

    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: got %0d left over, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the 8-bit accumulator CPU core. Fetches one- and two-byte instructions from an asynchronous-read program ROM, decodes them, and drives every control input of the datapath. It consumes the datapath's zero/positive flags and branch address, which closes the datapath's control interface from the other side. It also owns the program counter, the user-input handshake, and the halt condition.

## Interface
- `RESET_PC`, default 8'h00: program counter value after reset.

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `prog_addr`  out  8  ROM address; equals PC
- `prog_data`  in  8  ROM data, valid combinationally for `prog_addr`
- `user_enter`  in  1  debounced, level-high user "enter" key
- `zero_flag_in`, `positive_flag_in`  in  1 each  datapath flags, derived from the accumulator's next value
- `branch_address_in`  in  8  datapath ALU output, used as an indirect jump target
- `mux_select`  out  2  accumulator source: 0 ALU, 1 RF, 2 IMM, 3 USER
- `imm_data`  out  8  operand register
- `acc_enable`, `rf_write`  out  1 each  datapath write strobes
- `rf_address`  out  3  IR[2:0]
- `alu_select`  out  4  operand[7:4]
- `alu_rotate`  out  2  operand[1:0]
- `output_enable`  out  1  display enable (registered)
- `waiting_input`  out  1  high while the core blocks on user input
- `halted`  out  1  high in HALT

## Operation
- Byte 0 holds the opcode in [7:4] and the register in [2:0]. Byte 1, when present, is the operand.
- One-byte opcodes:
  - 0 NOP
  - 1 IN: A <- user input
  - 2 LDA: A <- Rn
  - 3 STA: Rn <- A
  - 9 OUT: `output_enable` <- 1
  - A OFF: `output_enable` <- 0
  - F HALT
  - C/D/E execute as NOP.
- Two-byte opcodes:
  - 4 LDI: A <- imm
  - 5 ALU: A <- alu(A, Rn); the operand carries select/rotate
  - 6 JMP: PC <- operand
  - 7 JZ: jump if Z
  - 8 JP: jump if P
  - B JMPR: PC <- `branch_address_in`, with the ALU configured from the operand
- States and transitions:
  - FETCH: IR <- `prog_data`, PC+1. Two-byte opcode -> OPERAND, else -> EXECUTE.
  - OPERAND: operand <- `prog_data`, PC+1 -> EXECUTE.
  - EXECUTE: strobes asserted -> FETCH. IN -> WAIT_IN. HALT -> HALT.
  - WAIT_IN: `mux_select`=3. On `user_enter`=1, pulse `acc_enable` for one cycle -> WAIT_RELEASE.
  - WAIT_RELEASE: hold until `user_enter`=0 -> FETCH. A key held down therefore loads the accumulator exactly once.
  - HALT: absorbing state; only reset leaves it.
- Strobes are combinational from state and IR. Outside EXECUTE and the WAIT_IN capture cycle, `acc_enable` and `rf_write` are 0.
- The flag latches Z and P capture `zero_flag_in` / `positive_flag_in` on every edge where `acc_enable`=1. JZ/JP test the latched values, never the live inputs.
- PC is 8-bit and wraps 8'hFF -> 8'h00, including wrap between byte 0 and byte 1 of one instruction.
- A taken jump overrides the PC increment. An untaken JZ/JP leaves PC pointing at the next instruction.

## Timing
- Reset values (asynchronous, immediate):
  - state FETCH, PC=`RESET_PC`
  - IR=0, operand=0
  - Z=1, P=1
  - `output_enable`=0, `halted`=0, `waiting_input`=0
  - all strobes 0
- Reset asserted mid-instruction abandons it with no partial write.
- Cycle counts:
  - One-byte instruction: 2 cycles (FETCH, EXECUTE).
  - Two-byte instruction: 3 cycles.
  - IN: 2 cycles + wait time + 1 capture cycle + release.
- The datapath writes A/Rn on the clock edge ending EXECUTE. The flags latch on that same edge.
- A jump target is fetched in the cycle after EXECUTE.
- `user_enter` already high when IN reaches WAIT_IN: capture in the first WAIT_IN cycle.
- `user_enter` must see a low between two IN instructions, because of WAIT_RELEASE.
- `waiting_input`=1 in WAIT_IN and WAIT_RELEASE. `halted`=1 in the HALT state.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams (`OP_NOP`…`OP_HALT`)
  - mux-select constants `MUX_ALU`/`MUX_RF`/`MUX_IMM`/`MUX_USER`
  - the state enumeration
  - a `two_byte(opcode)` function
- One sub-module, `instruction_decoder`: purely combinational. Maps state, IR and operand to strobes, `mux_select`, and the jump/is-two-byte decision.
- The FSM, PC, IR, operand and flag latches stay in `control_unit`.

## Test plan
- **Reset mid-ALU:** assert reset during OPERAND of `50 3C` -> `prog_addr`=00, no `acc_enable`, Z=P=1, `output_enable`=0.
- **LDI/STA/ALU sequence:** ROM `40 05`, `33`, `50 xx` -> `mux_select`=2, `imm_data`=05, `acc_enable` on cycle 3. `rf_write` with `rf_address`=3 on cycle 5. ALU strobes with `alu_select`/`alu_rotate` taken from xx.
- **JZ taken/untaken:** load 00, then `70 20` -> PC=20 next fetch. Load 80, then `70 20` -> falls through, and P latched 0 (so `80 40` also falls through).
- **Input handshake:** `10` with `user_enter` held high for 5 cycles -> exactly one `acc_enable` pulse with `mux_select`=3. `waiting_input` stays high until release.
- **PC wrap:** `40` at FF, `07` at 00 -> operand 07, next fetch at 01.
- **JMPR/OUT/HALT:** `B2 yy` -> next `prog_addr`=`branch_address_in`. `90` raises `output_enable`. `F0` -> `halted`=1, PC frozen, no strobes for 20 cycles.
